// File: rtl/setting_cmd_decoder.sv
// Decodes short ASCII frames (OP IDX TERM, or 'X' TERM) from a byte stream
// into one-cycle turnOn/turnOff/toggle pulse vectors plus a per-frame ack/err.
module setting_cmd_decoder #(
  parameter int NUM_SETTINGS   = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rxData,
  input  logic                    rxValid,
  output logic [NUM_SETTINGS-1:0] turnOn,
  output logic [NUM_SETTINGS-1:0] turnOff,
  output logic [NUM_SETTINGS-1:0] toggle,
  output logic                    cmdAck,
  output logic                    cmdErr
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_IDX, WAIT_TERM} state_t;
  typedef enum logic [1:0] {OP_ON, OP_OFF, OP_TOG} op_t;

  state_t                  state, state_n;
  op_t                     op, op_n;
  logic [NUM_SETTINGS-1:0] mask, mask_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [NUM_SETTINGS-1:0] on_n, off_n, tog_n;
  logic                    ack_n, err_n;
  logic [NUM_SETTINGS-1:0] onehot;
  logic                    is_term, timed_out;

  // One-hot index decode; an all-zero result means the byte is not a legal index.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_SETTINGS; i++)
      onehot[i] = (rxData == 8'(48 + i));
  end

  assign is_term   = (rxData == 8'h0A) || (rxData == 8'h0D);
  // A byte in the limit cycle wins over the timeout, so only idle cycles expire.
  assign timed_out = !rxValid && (cnt == LIMIT);

  // Next-state, latched frame fields and next registered pulses.
  always_comb begin
    state_n = state;
    op_n    = op;
    mask_n  = mask;
    cnt_n   = '0;
    on_n    = '0;
    off_n   = '0;
    tog_n   = '0;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (rxValid) begin
          case (rxData)
            8'h4E: begin op_n = OP_ON;  state_n = WAIT_IDX; end
            8'h46: begin op_n = OP_OFF; state_n = WAIT_IDX; end
            8'h54: begin op_n = OP_TOG; state_n = WAIT_IDX; end
            8'h58: begin op_n = OP_OFF; mask_n = '1; state_n = WAIT_TERM; end
            default: ; // terminators and garbage are dropped silently
          endcase
        end
      end
      WAIT_IDX: begin
        if (rxValid) begin
          if (|onehot) begin
            mask_n  = onehot;
            state_n = WAIT_TERM;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end else if (timed_out) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_TERM: begin
        if (rxValid) begin
          state_n = IDLE;
          if (is_term) begin
            ack_n = 1'b1;
            case (op)
              OP_ON:   on_n  = mask;
              OP_OFF:  off_n = mask;
              OP_TOG:  tog_n = mask;
              default: ;
            endcase
          end else begin
            err_n = 1'b1;
          end
        end else if (timed_out) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, frame fields, timeout counter and pulse outputs; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      op      <= OP_ON;
      mask    <= '0;
      cnt     <= '0;
      turnOn  <= '0;
      turnOff <= '0;
      toggle  <= '0;
      cmdAck  <= 1'b0;
      cmdErr  <= 1'b0;
    end else begin
      state   <= state_n;
      op      <= op_n;
      mask    <= mask_n;
      cnt     <= cnt_n;
      turnOn  <= on_n;
      turnOff <= off_n;
      toggle  <= tog_n;
      cmdAck  <= ack_n;
      cmdErr  <= err_n;
    end
  end

endmodule

// File: tb/tb_setting_cmd_decoder.sv
// Directed table-driven bench for setting_cmd_decoder (8 settings, 16-cycle timeout).
module tb_setting_cmd_decoder;

  localparam int NS = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rxData = 8'h00;
  logic          rxValid = 1'b0;
  logic [NS-1:0] turnOn, turnOff, toggle;
  logic          cmdAck, cmdErr;

  int checks = 0;
  int errors = 0;

  setting_cmd_decoder #(.NUM_SETTINGS(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rxData(rxData), .rxValid(rxValid),
    .turnOn(turnOn), .turnOff(turnOff), .toggle(toggle),
    .cmdAck(cmdAck), .cmdErr(cmdErr)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus and the outputs expected right after that edge.
  typedef struct {
    logic          rst_n;
    logic          vld;
    logic [7:0]    d;
    logic [NS-1:0] on;
    logic [NS-1:0] off;
    logic [NS-1:0] tog;
    logic          ack;
    logic          err;
  } vec_t;

  function automatic vec_t mk(logic r, logic v, logic [7:0] d,
                              logic [NS-1:0] on, logic [NS-1:0] off,
                              logic [NS-1:0] tog, logic ack, logic err);
    vec_t x;
    x.rst_n = r; x.vld = v; x.d = d;
    x.on = on; x.off = off; x.tog = tog; x.ack = ack; x.err = err;
    return x;
  endfunction

  // Byte with all outputs expected quiet.
  function automatic vec_t b(logic [7:0] d);
    return mk(1'b1, 1'b1, d, '0, '0, '0, 1'b0, 1'b0);
  endfunction

  // Idle cycle with all outputs expected quiet.
  function automatic vec_t idle();
    return mk(1'b1, 1'b0, 8'h00, '0, '0, '0, 1'b0, 1'b0);
  endfunction

  task automatic chk(string name, logic [NS-1:0] act, logic [NS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(string tag, vec_t v);
    @(negedge clk);
    rst_n   = v.rst_n;
    rxValid = v.vld;
    rxData  = v.d;
    @(posedge clk);
    #1;
    chk({tag, ".turnOn"},  turnOn,  v.on);
    chk({tag, ".turnOff"}, turnOff, v.off);
    chk({tag, ".toggle"},  toggle,  v.tog);
    chk({tag, ".cmdAck"},  NS'(cmdAck), NS'(v.ack));
    chk({tag, ".cmdErr"},  NS'(cmdErr), NS'(v.err));
  endtask

  vec_t tbl[$];

  initial begin
    // reset
    tbl.push_back(mk(1'b0, 1'b0, 8'h00, '0, '0, '0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 8'h4E, '0, '0, '0, 1'b0, 1'b0));
    // N 3 LF -> turnOn bit 3
    tbl.push_back(b(8'h4E));
    tbl.push_back(b(8'h33));
    tbl.push_back(mk(1'b1, 1'b1, 8'h0A, 8'h08, '0, '0, 1'b1, 1'b0));
    tbl.push_back(idle());
    // T 0 CR then F 7 LF back to back
    tbl.push_back(b(8'h54));
    tbl.push_back(b(8'h30));
    tbl.push_back(mk(1'b1, 1'b1, 8'h0D, '0, '0, 8'h01, 1'b1, 1'b0));
    tbl.push_back(b(8'h46));
    tbl.push_back(b(8'h37));
    tbl.push_back(mk(1'b1, 1'b1, 8'h0A, '0, 8'h80, '0, 1'b1, 1'b0));
    // X LF -> all off, immediately followed by out-of-range index
    tbl.push_back(b(8'h58));
    tbl.push_back(mk(1'b1, 1'b1, 8'h0A, '0, 8'hFF, '0, 1'b1, 1'b0));
    tbl.push_back(b(8'h4E));
    tbl.push_back(mk(1'b1, 1'b1, 8'h38, '0, '0, '0, 1'b0, 1'b1));
    tbl.push_back(b(8'h0A));
    // F 1 T LF -> error on T, LF ignored; garbage in IDLE ignored
    tbl.push_back(b(8'h46));
    tbl.push_back(b(8'h31));
    tbl.push_back(mk(1'b1, 1'b1, 8'h54, '0, '0, '0, 1'b0, 1'b1));
    tbl.push_back(b(8'h0A));
    tbl.push_back(b(8'h41));
    tbl.push_back(b(8'h0D));
    // opcode where index expected -> error
    tbl.push_back(b(8'h4E));
    tbl.push_back(mk(1'b1, 1'b1, 8'h4E, '0, '0, '0, 1'b0, 1'b1));
    // byte just below '0' is not an index
    tbl.push_back(b(8'h54));
    tbl.push_back(mk(1'b1, 1'b1, 8'h2F, '0, '0, '0, 1'b0, 1'b1));
    // N 2 then reset (with a byte present), then LF -> nothing
    tbl.push_back(b(8'h4E));
    tbl.push_back(b(8'h32));
    tbl.push_back(mk(1'b0, 1'b1, 8'h0A, '0, '0, '0, 1'b0, 1'b0));
    tbl.push_back(b(8'h0A));
    tbl.push_back(idle());
    // decoder still works after reset; T 5 LF toggles bit 5
    tbl.push_back(b(8'h54));
    tbl.push_back(b(8'h35));
    tbl.push_back(mk(1'b1, 1'b1, 8'h0A, '0, '0, 8'h20, 1'b1, 1'b0));
    // X then garbage -> error
    tbl.push_back(b(8'h58));
    tbl.push_back(mk(1'b1, 1'b1, 8'h58, '0, '0, '0, 1'b0, 1'b1));

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("vec%0d", i), tbl[i]);

    // Timeout in WAIT_IDX: error exactly TO cycles after the opcode, once.
    apply("to_op", b(8'h4E));
    for (int i = 1; i < TO; i++)
      apply($sformatf("to_wait%0d", i), idle());
    apply("to_err", mk(1'b1, 1'b0, 8'h00, '0, '0, '0, 1'b0, 1'b1));
    apply("to_after", idle());
    apply("to_n", b(8'h4E));
    apply("to_i", b(8'h31));
    apply("to_lf", mk(1'b1, 1'b1, 8'h0A, 8'h02, '0, '0, 1'b1, 1'b0));

    // Byte arriving in the limit cycle wins; counter then restarts.
    apply("bw_op", b(8'h46));
    for (int i = 1; i < TO; i++)
      apply($sformatf("bw_wait%0d", i), idle());
    apply("bw_idx", b(8'h34));
    for (int i = 1; i < TO; i++)
      apply($sformatf("bw_wait2_%0d", i), idle());
    apply("bw_lf", mk(1'b1, 1'b1, 8'h0D, '0, 8'h10, '0, 1'b1, 1'b0));

    // Timeout in WAIT_TERM.
    apply("tt_op", b(8'h4E));
    apply("tt_idx", b(8'h36));
    for (int i = 1; i < TO; i++)
      apply($sformatf("tt_wait%0d", i), idle());
    apply("tt_err", mk(1'b1, 1'b0, 8'h00, '0, '0, '0, 1'b0, 1'b1));
    apply("tt_lf", b(8'h0A));
    apply("tt_quiet", idle());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/setting_cmd_decoder.md
Name: setting_cmd_decoder

Overview:
Byte-level command decoder that sits directly upstream of the bank of single-bit system-setting registers. It consumes received serial bytes (one byte per rxValid cycle) and parses short ASCII frames. It emits one-cycle turnOn/turnOff/toggle pulse vectors, one bit per downstream setting register. Each frame ends in exactly one ack or error pulse for host feedback.

Parameters:
NUM_SETTINGS, 8, number of downstream setting registers; legal range 1..10.
TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes of one frame before it is abandoned; must be >= 2.

Ports:
clk  input  1  system clock; all logic on its rising edge
rst_n  input  1  synchronous active-low reset
rxData  input  8  received byte; sampled only when rxValid=1
rxValid  input  1  byte strobe; every cycle it is high counts as one new byte
turnOn  output  NUM_SETTINGS  one-cycle pulse, bit i sets setting i
turnOff  output  NUM_SETTINGS  one-cycle pulse, bit i clears setting i
toggle  output  NUM_SETTINGS  one-cycle pulse, bit i inverts setting i
cmdAck  output  1  one-cycle pulse: frame executed
cmdErr  output  1  one-cycle pulse: frame rejected or timed out

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). The polarity and synchronicity are fixed.
- Frame format: OP IDX TERM, or 'X' TERM.
  - OP: 'N'(0x4E)=on, 'F'(0x46)=off, 'T'(0x54)=toggle, 'X'(0x58)=all off.
  - IDX: ASCII '0'..('0'+NUM_SETTINGS-1).
  - TERM: 0x0A or 0x0D.
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE; the timeout counter clears.
  - All outputs are 0 from the next cycle.
  - A partially received frame is discarded without cmdErr.
  - Reset overrides rxValid in the same cycle.
- States:
  - IDLE:
    - Byte N/F/T: latch the opcode, go to WAIT_IDX.
    - Byte X: latch an all-ones mask with opcode off, go to WAIT_TERM.
    - Byte 0x0A or 0x0D: ignored, stay in IDLE.
    - Any other byte: ignored silently, stay in IDLE, no cmdErr.
  - WAIT_IDX:
    - Legal index byte: latch a one-hot mask, go to WAIT_TERM.
    - Any other byte, including an opcode: cmdErr pulse, go to IDLE, byte discarded.
  - WAIT_TERM:
    - 0x0A or 0x0D: execute, go to IDLE.
    - Any other byte: cmdErr pulse, go to IDLE, byte discarded.
- Execute:
  - Registered outputs: the pulse vector and cmdAck assert exactly 1 cycle after the clk edge that samples TERM.
  - Pulses last one cycle; only the latched opcode's vector is nonzero, and it equals the latched mask.
  - The other two vectors are 0, so no two vectors are ever nonzero in the same cycle.
- Back-to-back frames:
  - The FSM is already in IDLE on the execute cycle, so a new OP byte in the very next cycle is accepted.
  - No bubble is required between frames.
- Timeout:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 runs only in WAIT_IDX/WAIT_TERM.
  - It clears on entry and on every accepted byte.
  - If it reaches TIMEOUT_CYCLES-1 with no byte in that cycle: cmdErr pulse next cycle, go to IDLE.
  - If a byte arrives in the same cycle the limit is hit, the byte wins and no timeout occurs.
- cmdAck and cmdErr are mutually exclusive. Each frame produces exactly one of them, except frames discarded by reset, which produce neither.
- Outputs are 0 in every cycle without an execute or error event.
- Latency: 1 clk from the final byte to the pulse. Throughput: one byte per clk.

Test Plan:
- Reset, then send 'N','3',0x0A on consecutive cycles -> one cycle after 0x0A: turnOn=0x08, turnOff=0, toggle=0, cmdAck=1; all outputs 0 on the following cycle.
- Send 'T','0',0x0D immediately followed by 'F','7',0x0A with no gaps -> toggle=0x01 with cmdAck on cycle 4; turnOff=0x80 with cmdAck on cycle 7; no cmdErr.
- Send 'X',0x0A -> turnOff=0xFF, cmdAck=1; then send 'N','8',0x0A (NUM_SETTINGS=8) -> cmdErr=1 one cycle after '8'; 0x0A ignored in IDLE; all pulse vectors stay 0.
- Send 'N' then no byte, with TIMEOUT_CYCLES=16 -> cmdErr pulses exactly once, 16 cycles after 'N'; a following 'N','1',0x0A gives turnOn=0x02.
- Send 'N','2' then assert rst_n=0 for one cycle, then send 0x0A -> no pulse, no cmdAck, no cmdErr; the FSM stays in IDLE.
- Send 'F','1','T',0x0A -> cmdErr after 'T'; the 0x0A is ignored; no pulses. Garbage byte 0x41 in IDLE -> no output activity.
